tcp_tx_seg_engine: RTL and testbench

//  Per-flow TCP transmit path; the send-side counterpart of the RX datapath. Takes one scheduler

---
 rtl/tcp_tx_seg_engine_pkg.sv | 87 ++++++++
 rtl/tcp_tx_seg_engine_calc.sv | 40 ++++
 rtl/tcp_tx_seg_engine.sv | 156 +++++++++++++++
 tb/tb_tcp_tx_seg_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_tx_seg_engine_pkg.sv
// Shared types and constants for the TCP transmit segment engine.
// Holds the scheduler command encodings, flow state records, the packet
// header / payload descriptor layouts and a small header builder.
package tcp_tx_seg_engine_pkg;

  localparam int unsigned FLOWID_W         = 4;
  localparam int unsigned TX_PAYLOAD_PTR_W = 15;
  localparam int unsigned PTR_W1           = TX_PAYLOAD_PTR_W + 1;
  localparam int unsigned IP_ADDR_W        = 32;
  localparam int unsigned MSS_BYTES        = 1460;
  localparam int unsigned HDR_WORDS        = 5;

  // Scheduler pending-field encodings
  localparam logic [1:0] PEND_NOP   = 2'd0;
  localparam logic [1:0] PEND_SET   = 2'd1;
  localparam logic [1:0] PEND_CLEAR = 2'd2;

  localparam logic [8:0] TCP_FLAG_ACK = 9'h010;
  localparam logic [8:0] TCP_FLAG_PSH = 9'h008;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    logic [1:0]          ack_pend;
    logic [1:0]          data_pend;
    logic [1:0]          rt_pend;
  } sched_cmd_t;

  typedef struct packed {
    logic [31:0] our_seq_num;
  } smol_tx_state_t;

  typedef struct packed {
    logic [31:0] ack_num;
  } ack_state_t;

  typedef struct packed {
    logic [31:0]       their_ack_num;
    logic [PTR_W1-1:0] their_win_size;
    logic [15:0]       our_win_size;
    ack_state_t        our_ack_state;
  } smol_rx_state_t;

  typedef struct packed {
    logic [IP_ADDR_W-1:0] host_ip;
    logic [IP_ADDR_W-1:0] dest_ip;
    logic [15:0]          host_port;
    logic [15:0]          dest_port;
  } four_tuple_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  data_offset;
    logic [2:0]  reserved;
    logic [8:0]  flags;
    logic [15:0] win_size;
    logic [15:0] chksum;
    logic [15:0] urg_ptr;
  } tcp_pkt_hdr_t;

  typedef struct packed {
    logic [TX_PAYLOAD_PTR_W-1:0] payload_addr;
    logic [PTR_W1-1:0]           payload_len;
  } payload_buf_t;

  // Checksum is left zero; it is filled in further down the TX pipe.
  function automatic tcp_pkt_hdr_t build_tcp_hdr(input logic [15:0] src_port,
                                                 input logic [15:0] dst_port,
                                                 input logic [31:0] seq_num,
                                                 input logic [31:0] ack_num,
                                                 input logic [15:0] win_size,
                                                 input logic        has_data);
    tcp_pkt_hdr_t h;
    h             = '0;
    h.src_port    = src_port;
    h.dst_port    = dst_port;
    h.seq_num     = seq_num;
    h.ack_num     = ack_num;
    h.data_offset = 4'(HDR_WORDS);
    h.flags       = TCP_FLAG_ACK | (has_data ? TCP_FLAG_PSH : 9'h000);
    h.win_size    = win_size;
    return h;
  endfunction

endpackage

// File: rtl/tcp_tx_seg_engine_calc.sv
// Combinational segment sizing.
// Ports: i_rt_pend / i_data_pend  decoded pending flags
//        i_our_seq_num, i_ack_num  next-to-send and peer-acked sequence numbers
//        i_tail                    application write pointer (PTR_W1 bits)
//        i_their_win               peer receive window
//        o_base_seq, o_payload_len segment start and length
// Pointer math is modulo 2^PTR_W1 so tail/seq wrap is handled naturally.
module tcp_tx_seg_engine_calc
  import tcp_tx_seg_engine_pkg::*;
(
  input  logic              i_rt_pend,
  input  logic              i_data_pend,
  input  logic [31:0]       i_our_seq_num,
  input  logic [31:0]       i_ack_num,
  input  logic [PTR_W1-1:0] i_tail,
  input  logic [PTR_W1-1:0] i_their_win,
  output logic [31:0]       o_base_seq,
  output logic [PTR_W1-1:0] o_payload_len
);

  localparam logic [PTR_W1-1:0] MssW = PTR_W1'(MSS_BYTES);

  logic [31:0]       w_base_seq;
  logic [PTR_W1-1:0] w_unsent;
  logic [PTR_W1-1:0] w_inflight;
  logic [PTR_W1-1:0] w_win_avail;
  logic [PTR_W1-1:0] w_min_a;

  // Retransmit restarts from the last acked byte (go-back-N)
  assign w_base_seq  = i_rt_pend ? i_ack_num : i_our_seq_num;
  assign w_unsent    = i_tail - w_base_seq[PTR_W1-1:0];
  assign w_inflight  = w_base_seq[PTR_W1-1:0] - i_ack_num[PTR_W1-1:0];
  assign w_win_avail = (i_their_win > w_inflight) ? (i_their_win - w_inflight) : '0;
  assign w_min_a     = (w_unsent < w_win_avail) ? w_unsent : w_win_avail;

  assign o_base_seq    = w_base_seq;
  assign o_payload_len = !(i_rt_pend || i_data_pend) ? '0 :
                         (w_min_a < MssW) ? w_min_a : MssW;

endmodule

// File: rtl/tcp_tx_seg_engine.sv
// Per-flow TCP transmit segment engine.
// Accepts one scheduler command, reads the flow's TX/RX state, tail pointer
// and four-tuple from 1-cycle synchronous RAMs, sizes one segment, emits
// header + IPs + payload descriptor, then writes back our_seq_num.
// Ports: i_clk/i_rst           clock, async active-high reset
//        i/o_sched_cmd_*       command handshake (ready only in idle)
//        o_*_rd_req_addr       flow-indexed RAM read addresses
//        i_*_rd_resp           RAM read data, valid the cycle after the address
//        o_tx_state_wr_req_*   sequence number writeback
//        o_tx_pkt_* / i_tx_pkt_rdy  segment output handshake
module tcp_tx_seg_engine
  import tcp_tx_seg_engine_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sched_cmd_val,
  output logic                 o_sched_cmd_rdy,
  input  sched_cmd_t           i_sched_cmd,
  output logic [FLOWID_W-1:0]  o_tx_state_rd_req_addr,
  output logic [FLOWID_W-1:0]  o_rx_state_rd_req_addr,
  output logic [FLOWID_W-1:0]  o_tx_tail_ptr_rd_req_addr,
  output logic [FLOWID_W-1:0]  o_flow_tuple_rd_req_addr,
  input  smol_tx_state_t       i_tx_state_rd_resp,
  input  smol_rx_state_t       i_rx_state_rd_resp,
  input  logic [PTR_W1-1:0]    i_tx_tail_ptr_rd_resp,
  input  four_tuple_t          i_flow_tuple_rd_resp,
  output logic                 o_tx_state_wr_req_val,
  output logic [FLOWID_W-1:0]  o_tx_state_wr_req_addr,
  output smol_tx_state_t       o_tx_state_wr_req_data,
  output logic                 o_tx_pkt_val,
  input  logic                 i_tx_pkt_rdy,
  output tcp_pkt_hdr_t         o_tx_pkt_hdr,
  output logic [IP_ADDR_W-1:0] o_tx_pkt_src_ip,
  output logic [IP_ADDR_W-1:0] o_tx_pkt_dst_ip,
  output payload_buf_t         o_tx_pkt_payload
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdResp, StCalc, StSend, StWb} state_e;

  state_e               r_state, w_state_next;
  sched_cmd_t           r_cmd;
  logic [31:0]          r_our_seq;
  smol_rx_state_t       r_rx_state;
  logic [PTR_W1-1:0]    r_tail;
  four_tuple_t          r_tuple;
  tcp_pkt_hdr_t         r_hdr;
  logic [IP_ADDR_W-1:0] r_src_ip;
  logic [IP_ADDR_W-1:0] r_dst_ip;
  payload_buf_t         r_payload;
  logic [31:0]          r_wb_seq;

  logic [FLOWID_W-1:0]  w_rd_addr;
  logic [31:0]          w_base_seq;
  logic [PTR_W1-1:0]    w_payload_len;
  logic                 w_drop;

  tcp_tx_seg_engine_calc u_calc (
    .i_rt_pend     (r_cmd.rt_pend == PEND_SET),
    .i_data_pend   (r_cmd.data_pend == PEND_SET),
    .i_our_seq_num (r_our_seq),
    .i_ack_num     (r_rx_state.our_ack_state.ack_num),
    .i_tail        (r_tail),
    .i_their_win   (r_rx_state.their_win_size),
    .o_base_seq    (w_base_seq),
    .o_payload_len (w_payload_len)
  );

  // Nothing to say: no data to send and no ACK owed
  assign w_drop = (w_payload_len == '0) && (r_cmd.ack_pend != PEND_SET);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    o_sched_cmd_rdy       = 1'b0;
    w_rd_addr             = '0;
    o_tx_pkt_val          = 1'b0;
    o_tx_state_wr_req_val = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Ready is forced low while reset is asserted
        o_sched_cmd_rdy = !i_rst;
        if (i_sched_cmd_val && !i_rst) w_state_next = StRdReq;
      end
      StRdReq: begin
        w_rd_addr    = r_cmd.flowid;
        w_state_next = StRdResp;
      end
      StRdResp: w_state_next = StCalc;
      StCalc:   w_state_next = w_drop ? StIdle : StSend;
      StSend: begin
        o_tx_pkt_val = 1'b1;
        if (i_tx_pkt_rdy) w_state_next = StWb;
      end
      StWb: begin
        o_tx_state_wr_req_val = 1'b1;
        w_state_next          = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd      <= '0;
      r_our_seq  <= '0;
      r_rx_state <= '0;
      r_tail     <= '0;
      r_tuple    <= '0;
      r_hdr      <= '0;
      r_src_ip   <= '0;
      r_dst_ip   <= '0;
      r_payload  <= '0;
      r_wb_seq   <= '0;
    end else begin
      if (r_state == StIdle && i_sched_cmd_val) r_cmd <= i_sched_cmd;
      if (r_state == StRdResp) begin
        r_our_seq  <= i_tx_state_rd_resp.our_seq_num;
        r_rx_state <= i_rx_state_rd_resp;
        r_tail     <= i_tx_tail_ptr_rd_resp;
        r_tuple    <= i_flow_tuple_rd_resp;
      end
      // Output fields only change here, so they hold through backpressure
      if (r_state == StCalc && !w_drop) begin
        r_hdr <= build_tcp_hdr(r_tuple.host_port, r_tuple.dest_port, w_base_seq,
                               r_rx_state.their_ack_num, r_rx_state.our_win_size,
                               w_payload_len != '0);
        r_src_ip               <= r_tuple.host_ip;
        r_dst_ip               <= r_tuple.dest_ip;
        r_payload.payload_addr <= w_base_seq[TX_PAYLOAD_PTR_W-1:0];
        r_payload.payload_len  <= w_payload_len;
        r_wb_seq               <= w_base_seq + 32'(w_payload_len);
      end
    end
  end

  assign o_tx_state_rd_req_addr    = w_rd_addr;
  assign o_rx_state_rd_req_addr    = w_rd_addr;
  assign o_tx_tail_ptr_rd_req_addr = w_rd_addr;
  assign o_flow_tuple_rd_req_addr  = w_rd_addr;

  assign o_tx_state_wr_req_addr          = r_cmd.flowid;
  assign o_tx_state_wr_req_data.our_seq_num = r_wb_seq;

  assign o_tx_pkt_hdr     = r_hdr;
  assign o_tx_pkt_src_ip  = r_src_ip;
  assign o_tx_pkt_dst_ip  = r_dst_ip;
  assign o_tx_pkt_payload = r_payload;

endmodule

// File: tb/tb_tcp_tx_seg_engine.sv
// Scoreboard bench for tcp_tx_seg_engine: directed cases plus random
// commands, each predicted by a plain-arithmetic reference model.
module tb_tcp_tx_seg_engine;
  import tcp_tx_seg_engine_pkg::*;

  localparam int unsigned NFLOWS = 1 << FLOWID_W;
  localparam int unsigned MODP   = 1 << PTR_W1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 cmd_val = 1'b0;
  logic                 cmd_rdy;
  sched_cmd_t           cmd = '0;
  logic [FLOWID_W-1:0]  tx_addr, rx_addr, tail_addr, tup_addr;
  smol_tx_state_t       tx_resp = '0;
  smol_rx_state_t       rx_resp = '0;
  logic [PTR_W1-1:0]    tail_resp = '0;
  four_tuple_t          tup_resp = '0;
  logic                 wr_val;
  logic [FLOWID_W-1:0]  wr_addr;
  smol_tx_state_t       wr_data;
  logic                 pkt_val;
  logic                 pkt_rdy = 1'b0;
  tcp_pkt_hdr_t         pkt_hdr;
  logic [IP_ADDR_W-1:0] pkt_src, pkt_dst;
  payload_buf_t         pkt_pl;

  tcp_tx_seg_engine dut (
    .i_clk                     (clk),
    .i_rst                     (rst),
    .i_sched_cmd_val           (cmd_val),
    .o_sched_cmd_rdy           (cmd_rdy),
    .i_sched_cmd               (cmd),
    .o_tx_state_rd_req_addr    (tx_addr),
    .o_rx_state_rd_req_addr    (rx_addr),
    .o_tx_tail_ptr_rd_req_addr (tail_addr),
    .o_flow_tuple_rd_req_addr  (tup_addr),
    .i_tx_state_rd_resp        (tx_resp),
    .i_rx_state_rd_resp        (rx_resp),
    .i_tx_tail_ptr_rd_resp     (tail_resp),
    .i_flow_tuple_rd_resp      (tup_resp),
    .o_tx_state_wr_req_val     (wr_val),
    .o_tx_state_wr_req_addr    (wr_addr),
    .o_tx_state_wr_req_data    (wr_data),
    .o_tx_pkt_val              (pkt_val),
    .i_tx_pkt_rdy              (pkt_rdy),
    .o_tx_pkt_hdr              (pkt_hdr),
    .o_tx_pkt_src_ip           (pkt_src),
    .o_tx_pkt_dst_ip           (pkt_dst),
    .o_tx_pkt_payload          (pkt_pl)
  );

  // Flow tables behind 1-cycle synchronous read ports
  smol_tx_state_t    m_tx  [NFLOWS];
  smol_rx_state_t    m_rx  [NFLOWS];
  logic [PTR_W1-1:0] m_tail[NFLOWS];
  four_tuple_t       m_tup [NFLOWS];

  always @(posedge clk) begin
    tx_resp   <= m_tx[tx_addr];
    rx_resp   <= m_rx[rx_addr];
    tail_resp <= m_tail[tail_addr];
    tup_resp  <= m_tup[tup_addr];
  end

  typedef struct packed {
    tcp_pkt_hdr_t         hdr;
    logic [IP_ADDR_W-1:0] src;
    logic [IP_ADDR_W-1:0] dst;
    payload_buf_t         pl;
  } pkt_exp_t;

  typedef struct packed {
    logic [FLOWID_W-1:0] addr;
    logic [31:0]         seq;
  } wb_exp_t;

  pkt_exp_t q_pkt[$];
  wb_exp_t  q_wb[$];
  int total = 0;
  int bad   = 0;
  bit bp_hold = 1'b0;

  task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Random backpressure, changed away from the sampling edge
  always @(posedge clk) begin
    #1;
    pkt_rdy = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: every cycle a packet is offered it must equal the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_val) begin
        if (q_pkt.size() == 0) fail("pkt_unexpected");
        else begin
          check(pkt_rdy ? "pkt" : "pkt_hold", {pkt_hdr, pkt_src, pkt_dst, pkt_pl}, q_pkt[0]);
          if (pkt_rdy) void'(q_pkt.pop_front());
        end
      end
      if (wr_val) begin
        if (q_wb.size() == 0) fail("wb_unexpected");
        else begin
          check("wb", {wr_addr, wr_data.our_seq_num}, q_wb.pop_front());
        end
      end
    end
  end

  // Reference model: segment sizing straight from the rules, plain integers
  task automatic model(input sched_cmd_t c, output bit has_pkt, output pkt_exp_t p,
                       output wb_exp_t w);
    int unsigned seq, ackst, base, tail, unsent, inflight, win, avail, len;
    bit rt, dp;
    seq      = m_tx[c.flowid].our_seq_num;
    ackst    = m_rx[c.flowid].our_ack_state.ack_num;
    tail     = m_tail[c.flowid];
    win      = m_rx[c.flowid].their_win_size;
    rt       = (c.rt_pend == 2'd1);
    dp       = (c.data_pend == 2'd1);
    base     = rt ? ackst : seq;
    unsent   = (tail - base) % MODP;
    inflight = (base - ackst) % MODP;
    avail    = (win > inflight) ? win - inflight : 0;
    len      = 0;
    if (rt || dp) begin
      len = unsent;
      if (avail < len) len = avail;
      if (1460 < len) len = 1460;
    end
    has_pkt            = (len != 0) || (c.ack_pend == 2'd1);
    p                  = '0;
    p.hdr.src_port     = m_tup[c.flowid].host_port;
    p.hdr.dst_port     = m_tup[c.flowid].dest_port;
    p.hdr.seq_num      = base;
    p.hdr.ack_num      = m_rx[c.flowid].their_ack_num;
    p.hdr.data_offset  = 4'd5;
    p.hdr.flags        = (len != 0) ? 9'h018 : 9'h010;
    p.hdr.win_size     = m_rx[c.flowid].our_win_size;
    p.src              = m_tup[c.flowid].host_ip;
    p.dst              = m_tup[c.flowid].dest_ip;
    p.pl.payload_addr  = TX_PAYLOAD_PTR_W'(base % (MODP / 2));
    p.pl.payload_len   = PTR_W1'(len);
    w.addr             = c.flowid;
    w.seq              = base + len;
  endtask

  task automatic set_flow(input int unsigned fid, input int unsigned seq, input int unsigned ackst,
                          input int unsigned tail, input int unsigned win);
    m_tx[fid].our_seq_num               = seq;
    m_rx[fid].our_ack_state.ack_num     = ackst;
    m_rx[fid].their_win_size            = PTR_W1'(win);
    m_rx[fid].their_ack_num             = $urandom;
    m_rx[fid].our_win_size              = 16'($urandom);
    m_tail[fid]                         = PTR_W1'(tail);
    m_tup[fid]                          = {$urandom, $urandom, $urandom};
  endtask

  function automatic sched_cmd_t mk_cmd(input int unsigned fid, input logic [1:0] a,
                                        input logic [1:0] d, input logic [1:0] r);
    sched_cmd_t c;
    c.flowid    = FLOWID_W'(fid);
    c.ack_pend  = a;
    c.data_pend = d;
    c.rt_pend   = r;
    return c;
  endfunction

  // Wait for ready, push the prediction, present the command for one cycle.
  task automatic send_cmd(input sched_cmd_t c, output bit hp);
    pkt_exp_t p;
    wb_exp_t  w;
    int n = 0;
    model(c, hp, p, w);
    while (!cmd_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) begin
      $display("FAIL cmd_rdy_timeout: got 0 expected 1");
      $fatal(1);
    end
    if (hp) begin
      q_pkt.push_back(p);
      q_wb.push_back(w);
    end
    cmd_val = 1'b1;
    cmd     = c;
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  task automatic issue(input sched_cmd_t c);
    bit hp;
    int n;
    int lat_val = -1;
    send_cmd(c, hp);
    n = 1;
    while (n < 300) begin
      if (pkt_val && lat_val < 0) lat_val = n;
      if (cmd_rdy) break;
      @(negedge clk);
      n++;
    end
    check("cmd_done", cmd_rdy, 1'b1);
    if (hp) check("pkt_latency", lat_val, 4);
    else begin
      check("drop_no_pkt", lat_val, -1);
      check("drop_rdy_latency", n, 4);
    end
    check("pkt_q_drained", q_pkt.size(), 0);
    check("wb_q_drained", q_wb.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hp;
    for (int i = 0; i < int'(NFLOWS); i++) set_flow(i, 0, 0, 0, 0);
    #12;
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_pkt_val", pkt_val, 1'b0);
    check("rst_wr_val", wr_val, 1'b0);
    check("rst_rd_addr", tx_addr, 0);
    check("rst_wr_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_rdy", cmd_rdy, 1'b1);

    // Pure ACK, nothing unsent
    set_flow(1, 'h100, 'h100, 'h100, 'hFFFF);
    issue(mk_cmd(1, PEND_SET, PEND_NOP, PEND_NOP));
    // Full MSS
    set_flow(2, 'h100, 'h100, 'h1000, 'hFFFF);
    issue(mk_cmd(2, PEND_NOP, PEND_SET, PEND_NOP));
    // Window limited: inflight 0x200, window 0x300, unsent 0x800
    set_flow(3, 'h1200, 'h1000, 'h1A00, 'h300);
    issue(mk_cmd(3, PEND_NOP, PEND_SET, PEND_NOP));
    // Retransmit from ack point
    set_flow(4, 'h900, 'h500, 'h900, 'hFFFF);
    issue(mk_cmd(4, PEND_NOP, PEND_NOP, PEND_SET));
    // Pointer wrap
    set_flow(5, 'h1234FFF0, 'h1234FFF0, 'h0010, 'hFFFF);
    issue(mk_cmd(5, PEND_NOP, PEND_SET, PEND_NOP));
    // Zero window with ACK owed
    set_flow(6, 'h2000, 'h1000, 'h3000, 'h800);
    issue(mk_cmd(6, PEND_SET, PEND_SET, PEND_NOP));
    // Data only, nothing unsent: dropped
    set_flow(7, 'h4000, 'h4000, 'h4000, 'hFFFF);
    issue(mk_cmd(7, PEND_CLEAR, PEND_SET, PEND_NOP));

    // Backpressure then asynchronous reset mid-send
    bp_hold = 1'b1;
    set_flow(8, 'h100, 'h100, 'h800, 'hFFFF);
    send_cmd(mk_cmd(8, PEND_SET, PEND_SET, PEND_NOP), hp);
    n = 0;
    while (!pkt_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_pkt_val", pkt_val, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_rst_pkt_val", pkt_val, 1'b0);
    check("abort_rst_wr_val", wr_val, 1'b0);
    check("abort_rst_hdr", pkt_hdr, 0);
    check("abort_rst_cmd_rdy", cmd_rdy, 1'b0);
    q_pkt.delete();
    q_wb.delete();
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    bp_hold = 1'b0;
    @(negedge clk);
    issue(mk_cmd(8, PEND_SET, PEND_SET, PEND_NOP));

    // Random flows and commands
    for (int i = 0; i < 150; i++) begin
      int unsigned fid, seq, win;
      fid = $urandom_range(0, NFLOWS - 1);
      seq = $urandom;
      win = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 'h400) : $urandom_range(0, 'hFFFF);
      set_flow(fid, seq, seq - $urandom_range(0, 'h800), seq + $urandom_range(0, 'h1000), win);
      issue(mk_cmd(fid, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                   2'($urandom_range(0, 2))));
    end

    repeat (3) @(negedge clk);
    check("end_pkt_q_empty", q_pkt.size(), 0);
    check("end_wb_q_empty", q_wb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
